// File: rtl/cnn_layer_accel_fas_vec_add_ctrl.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_fas_vec_add_ctrl
//
// Purpose:
//   Sequences the FAS vector-add pipeline. On a start pulse the job
//   configuration is latched. The block then issues one pipeline beat per
//   cycle, but only while every source FIFO required by the enabled adder
//   modes holds data and the sum FIFO has room. A beat pops the required
//   FIFOs and strobes the enabled adders. Beats walk the depth index
//   0..dpth_end once per pass, for num_pass passes, and then the block
//   pulses done.
//
// Optional feature:
//   VEC_ADD_CTRL_STALL_CNT_EN - when defined, builds a saturating 32-bit
//   counter of RUN cycles without a beat. When undefined, o_stall_cnt is
//   tied to 0.
//
// Handshake:
//   A FIFO pop happens in the cycle where o_*_fifo_rd_en is high. The FIFOs
//   are first-word-fall-through, so data is consumed in the same cycle.
//   o_pipe_enable is the only qualifier. It is high only when every required
//   source is non-empty and i_sum_fifo_full is low. A stalled cycle therefore
//   neither pops nor strobes anything.
//
// Ports:
//   i_clk_fas                      FAS clock, rising edge
//   i_rst_n                        asynchronous active-low reset
//   i_fas_rdy_n, i_process_cmpl    abort; either high returns to IDLE
//   i_start                        one-cycle job start (accepted in IDLE)
//   i_vec_add_en_cfg[4:0]          {pv, rm_conv, rm1, rm0, pm} enables
//   i_krnl1x1_dpth_end_cfg[15:0]   last depth-beat index (inclusive)
//   i_num_pass_cfg[15:0]           passes per job (0 means 1)
//   i_*_fifo_empty                 source FIFO empty flags
//   i_sum_fifo_full                downstream back-pressure
//   o_*_fifo_rd_en                 source FIFO pops
//   o_vector_add_*                 per-mode adder strobes
//   o_pipe_enable                  beat strobe
//   o_dpth_idx[15:0]               current depth-beat index
//   o_busy                         high in RUN and DONE
//   o_done                         one-cycle job-complete pulse
//   o_stall_cnt[31:0]              RUN stall-cycle count
//   o_dbg_state[1:0]               FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module cnn_layer_accel_fas_vec_add_ctrl (
   input  logic        i_clk_fas,
   input  logic        i_rst_n,
   input  logic        i_fas_rdy_n,
   input  logic        i_process_cmpl,
   input  logic        i_start,
   input  logic [4:0]  i_vec_add_en_cfg,
   input  logic [15:0] i_krnl1x1_dpth_end_cfg,
   input  logic [15:0] i_num_pass_cfg,
   input  logic        i_convmap_fifo_empty,
   input  logic        i_partmap_fifo_empty,
   input  logic        i_resdmap_fifo_empty,
   input  logic        i_prevmap_fifo_empty,
   input  logic        i_conv1x1_dwc_fifo_empty,
   input  logic        i_sum_fifo_full,
   output logic        o_convmap_fifo_rd_en,
   output logic        o_partmap_fifo_rd_en,
   output logic        o_resdmap_fifo_rd_en,
   output logic        o_prevmap_fifo_rd_en,
   output logic        o_conv1x1_dwc_fifo_rd_en,
   output logic        o_vector_add_pm,
   output logic        o_vector_add_rm0,
   output logic        o_vector_add_rm1,
   output logic        o_vector_add_rm_conv,
   output logic        o_vector_add_pv,
   output logic        o_pipe_enable,
   output logic [15:0] o_dpth_idx,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_stall_cnt,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [4:0]  r_en;
   logic [15:0] r_dpth_end;
   logic [15:0] r_num_pass;
   logic [15:0] r_dpth_idx;
   logic [15:0] r_pass_cnt;

   logic        w_abort;
   logic        w_start_acc;
   logic        w_req_conv;
   logic        w_req_part;
   logic        w_req_resd;
   logic        w_req_prev;
   logic        w_req_dwc;
   logic        w_src_rdy;
   logic        w_pipe_en;
   logic        w_dpth_wrap;
   logic        w_last_beat;

   assign w_abort     = i_fas_rdy_n | i_process_cmpl;
   // Abort has priority, so a start that arrives together with an abort is dropped.
   assign w_start_acc = i_start & (r_state == ST_IDLE) & ~w_abort;

   // Each FIFO is required when any enabled mode reads it.
   // r_en bit order: 0 pm, 1 rm0, 2 rm1, 3 rm_conv, 4 pv.
   assign w_req_conv = r_en[0] | r_en[1] | r_en[2];
   assign w_req_part = r_en[0] | r_en[2];
   assign w_req_resd = r_en[1] | r_en[2] | r_en[3];
   assign w_req_dwc  = r_en[3] | r_en[4];
   assign w_req_prev = r_en[4];

   assign w_src_rdy = (~w_req_conv | ~i_convmap_fifo_empty) &
                      (~w_req_part | ~i_partmap_fifo_empty) &
                      (~w_req_resd | ~i_resdmap_fifo_empty) &
                      (~w_req_prev | ~i_prevmap_fifo_empty) &
                      (~w_req_dwc  | ~i_conv1x1_dwc_fifo_empty);

   assign w_pipe_en   = (r_state == ST_RUN) & ~w_abort & w_src_rdy & ~i_sum_fifo_full;
   assign w_dpth_wrap = (r_dpth_idx == r_dpth_end);
   // r_num_pass is never 0 once a job is latched, so subtracting 1 cannot underflow in RUN.
   assign w_last_beat = w_pipe_en & w_dpth_wrap & (r_pass_cnt == (r_num_pass - 16'd1));

   // FSM state register
   always_ff @(posedge i_clk_fas or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  w_state_nxt = (i_vec_add_en_cfg == 5'd0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_last_beat) begin
                  w_state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Job configuration, captured only when a start is accepted
   always_ff @(posedge i_clk_fas or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_en       <= 5'd0;
         r_dpth_end <= 16'd0;
         r_num_pass <= 16'd0;
      end else if (w_start_acc) begin
         r_en       <= i_vec_add_en_cfg;
         r_dpth_end <= i_krnl1x1_dpth_end_cfg;
         r_num_pass <= (i_num_pass_cfg == 16'd0) ? 16'd1 : i_num_pass_cfg;
      end
   end

   // Depth and pass counters. They advance only on a beat, so a stall leaves them unchanged.
   always_ff @(posedge i_clk_fas or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dpth_idx <= 16'd0;
         r_pass_cnt <= 16'd0;
      end else if (w_abort || w_start_acc) begin
         r_dpth_idx <= 16'd0;
         r_pass_cnt <= 16'd0;
      end else if (w_pipe_en) begin
         if (w_dpth_wrap) begin
            r_dpth_idx <= 16'd0;
            r_pass_cnt <= r_pass_cnt + 16'd1;
         end else begin
            r_dpth_idx <= r_dpth_idx + 16'd1;
         end
      end
   end

`ifdef VEC_ADD_CTRL_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Counts RUN cycles without a beat, excluding abort cycles. It holds its value after done.
   always_ff @(posedge i_clk_fas or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= 32'd0;
      end else if (w_start_acc) begin
         r_stall_cnt <= 32'd0;
      end else if ((r_state == ST_RUN) && !w_abort && !w_pipe_en &&
                   (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
`else
   assign o_stall_cnt = 32'd0;
`endif

   assign o_pipe_enable            = w_pipe_en;
   assign o_convmap_fifo_rd_en     = w_pipe_en & w_req_conv;
   assign o_partmap_fifo_rd_en     = w_pipe_en & w_req_part;
   assign o_resdmap_fifo_rd_en     = w_pipe_en & w_req_resd;
   assign o_prevmap_fifo_rd_en     = w_pipe_en & w_req_prev;
   assign o_conv1x1_dwc_fifo_rd_en = w_pipe_en & w_req_dwc;

   assign o_vector_add_pm      = w_pipe_en & r_en[0];
   assign o_vector_add_rm0     = w_pipe_en & r_en[1];
   assign o_vector_add_rm1     = w_pipe_en & r_en[2];
   assign o_vector_add_rm_conv = w_pipe_en & r_en[3];
   assign o_vector_add_pv      = w_pipe_en & r_en[4];

   assign o_dpth_idx  = r_dpth_idx;
   assign o_busy      = (r_state == ST_RUN) | (r_state == ST_DONE);
   assign o_done      = (r_state == ST_DONE) & ~w_abort;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cnn_layer_accel_fas_vec_add_ctrl.sv
module tb_cnn_layer_accel_fas_vec_add_ctrl;

   localparam int BUDGET = 400;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        fas_rdy_n, process_cmpl, start;
   logic [4:0]  en_cfg;
   logic [15:0] end_cfg, pass_cfg;
   logic        conv_e, part_e, resd_e, prev_e, dwc_e, sum_full;
   logic        conv_rd, part_rd, resd_rd, prev_rd, dwc_rd;
   logic        va_pm, va_rm0, va_rm1, va_rmc, va_pv, pipe_en;
   logic [15:0] dpth_idx;
   logic        busy, done;
   logic [31:0] stall_cnt;
   logic [1:0]  dbg_state;
   logic [63:0] all_out;

   assign all_out = {1'b0, conv_rd, part_rd, resd_rd, prev_rd, dwc_rd,
                     va_pm, va_rm0, va_rm1, va_rmc, va_pv, pipe_en,
                     dpth_idx, busy, done, stall_cnt, dbg_state};

   cnn_layer_accel_fas_vec_add_ctrl dut (
      .i_clk_fas                (clk),
      .i_rst_n                  (rst_n),
      .i_fas_rdy_n              (fas_rdy_n),
      .i_process_cmpl           (process_cmpl),
      .i_start                  (start),
      .i_vec_add_en_cfg         (en_cfg),
      .i_krnl1x1_dpth_end_cfg   (end_cfg),
      .i_num_pass_cfg           (pass_cfg),
      .i_convmap_fifo_empty     (conv_e),
      .i_partmap_fifo_empty     (part_e),
      .i_resdmap_fifo_empty     (resd_e),
      .i_prevmap_fifo_empty     (prev_e),
      .i_conv1x1_dwc_fifo_empty (dwc_e),
      .i_sum_fifo_full          (sum_full),
      .o_convmap_fifo_rd_en     (conv_rd),
      .o_partmap_fifo_rd_en     (part_rd),
      .o_resdmap_fifo_rd_en     (resd_rd),
      .o_prevmap_fifo_rd_en     (prev_rd),
      .o_conv1x1_dwc_fifo_rd_en (dwc_rd),
      .o_vector_add_pm          (va_pm),
      .o_vector_add_rm0         (va_rm0),
      .o_vector_add_rm1         (va_rm1),
      .o_vector_add_rm_conv     (va_rmc),
      .o_vector_add_pv          (va_pv),
      .o_pipe_enable            (pipe_en),
      .o_dpth_idx               (dpth_idx),
      .o_busy                   (busy),
      .o_done                   (done),
      .o_stall_cnt              (stall_cnt),
      .o_dbg_state              (dbg_state)
   );

   // ---------------- scoreboard / reference model ----------------
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];      // expected depth index of every outstanding beat

   bit          m_run, m_done;
   logic [4:0]  m_en, m_mask;
   int          m_end, m_beat, m_total;
   logic [31:0] m_stall;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // FIFOs read by each mode. Mask bit order: 0 conv, 1 part, 2 resd, 3 prev, 4 dwc.
   function automatic logic [4:0] mode_fifos(input int b);
      case (b)
         0:       return 5'b00011;  // pm      : conv, part
         1:       return 5'b00101;  // rm0     : conv, resd
         2:       return 5'b00111;  // rm1     : conv, part, resd
         3:       return 5'b10100;  // rm_conv : dwc, resd
         default: return 5'b11000;  // pv      : dwc, prev
      endcase
   endfunction

   task automatic model_reset();
      m_run = 0; m_done = 0; m_en = 0; m_mask = 0;
      m_end = 0; m_beat = 0; m_total = 0; m_stall = 0;
      exp_q.delete();
   endtask

   // Compare the DUT against the model for the current cycle, then advance the model.
   task automatic check_step();
      logic        ab, e_pipe, e_busy, e_done;
      logic [4:0]  emp, e_rd, e_va;
      logic [15:0] e_dpth, q_dpth;
      ab     = fas_rdy_n | process_cmpl;
      emp    = {dwc_e, prev_e, resd_e, part_e, conv_e};
      e_pipe = m_run && !ab && ((m_mask & emp) == 5'd0) && !sum_full;
      e_rd   = e_pipe ? m_mask : 5'd0;
      e_va   = e_pipe ? m_en : 5'd0;
      e_busy = m_run || m_done;
      e_done = m_done && !ab;
      e_dpth = 16'(m_beat % (m_end + 1));
      chk("pipe_enable", 64'(pipe_en), 64'(e_pipe));
      chk("fifo_rd_en", 64'({dwc_rd, prev_rd, resd_rd, part_rd, conv_rd}), 64'(e_rd));
      chk("vector_add", 64'({va_pv, va_rmc, va_rm1, va_rm0, va_pm}), 64'(e_va));
      chk("busy_done", 64'({busy, done}), 64'({e_busy, e_done}));
      chk("dpth_idx", 64'(dpth_idx), 64'(e_dpth));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (pipe_en) begin
         if (exp_q.size() > 0) begin
            q_dpth = exp_q.pop_front();
            chk("beat_dpth", 64'(dpth_idx), 64'(q_dpth));
         end else begin
            chk("beat_unexpected", 64'(1), 64'(0));
         end
      end
      if (done) chk("beats_left_at_done", 64'(exp_q.size()), 64'(0));
      // advance
      if (ab) begin
         m_run = 0; m_done = 0; m_beat = 0;
         exp_q.delete();
      end else if (!m_run && !m_done) begin
         if (start) begin
            m_en    = en_cfg;
            m_mask  = 5'd0;
            for (int b = 0; b < 5; b++) if (en_cfg[b]) m_mask |= mode_fifos(b);
            m_end   = int'(end_cfg);
            m_total = (m_end + 1) * ((pass_cfg == 16'd0) ? 1 : int'(pass_cfg));
            m_beat  = 0;
            m_stall = 0;
            exp_q.delete();
            if (en_cfg == 5'd0) m_done = 1;
            else begin
               m_run = 1;
               for (int i = 0; i < m_total; i++) exp_q.push_back(16'(i % (m_end + 1)));
            end
         end
      end else if (m_run) begin
         if (e_pipe) begin
            m_beat++;
            if (m_beat == m_total) begin
               m_run = 0; m_done = 1;
            end
         end else begin
`ifdef VEC_ADD_CTRL_STALL_CNT_EN
            if (m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
         end
      end else begin
         m_done = 0;
      end
   endtask

   // ---------------- driver ----------------
   // mode 0: always ready; 1: prevMap empty at k=2..4; 2: sum full at even k;
   // 3: random empties/full plus start noise.
   task automatic drive_cycle(input int k, input int mode, input logic [4:0] cfg,
                              input logic [15:0] e, input logic [15:0] p,
                              input int abort_k, input bit abort_sel);
      start    = (k == 0);
      en_cfg   = (k == 0) ? cfg : 5'($urandom);
      end_cfg  = (k == 0) ? e : 16'($urandom);
      pass_cfg = (k == 0) ? p : 16'($urandom);
      {conv_e, part_e, resd_e, prev_e, dwc_e} = 5'd0;
      sum_full = 1'b0;
      case (mode)
         1: prev_e = (k >= 2 && k <= 4);
         2: sum_full = (k % 2 == 0);
         3: begin
            conv_e = ($urandom_range(0, 7) == 0);
            part_e = ($urandom_range(0, 7) == 0);
            resd_e = ($urandom_range(0, 7) == 0);
            prev_e = ($urandom_range(0, 7) == 0);
            dwc_e  = ($urandom_range(0, 7) == 0);
            sum_full = ($urandom_range(0, 7) == 0);
            if (k > 0) start = ($urandom_range(0, 7) == 0);
         end
         default: ;
      endcase
      process_cmpl = (k == abort_k) && !abort_sel;
      fas_rdy_n    = (k == abort_k) && abort_sel;
   endtask

   task automatic drive_idle();
      start = 0; fas_rdy_n = 0; process_cmpl = 0; sum_full = 0;
      {conv_e, part_e, resd_e, prev_e, dwc_e} = 5'd0;
   endtask

   task automatic run_job(input logic [4:0] cfg, input logic [15:0] e, input logic [15:0] p,
                          input int mode, input int abort_k, input bit abort_sel,
                          output int beats, output int done_k);
      beats = 0; done_k = -1;
      for (int k = 0; k < BUDGET; k++) begin
         drive_cycle(k, mode, cfg, e, p, abort_k, abort_sel);
         @(negedge clk);
         if (pipe_en) beats++;
         if (done && done_k < 0) done_k = k;
         check_step();
         @(posedge clk); #1;
         if (done_k >= 0 || k == abort_k) break;
      end
      if (abort_k < 0) chk("job_finished_in_budget", 64'(done_k >= 0), 64'(1));
      // one quiet cycle: back in IDLE, nothing strobes
      drive_idle();
      @(negedge clk);
      check_step();
      @(posedge clk); #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [4:0]  cfg;
      logic [15:0] e;
      logic [15:0] p;
      int          mode;
      int          abort_k;
      bit          abort_sel;
      int          exp_beats;
      int          exp_done_k;
      int          exp_stall;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats, done_k, st;
      //           cfg       e      p     mode abort sel beats done_k stall
      tbl[0] = '{5'b00001, 16'd3, 16'd2, 0, -1, 1'b0, 8, 9, 0};
      tbl[1] = '{5'b10000, 16'd1, 16'd2, 1, -1, 1'b0, 4, 8, 3};
      tbl[2] = '{5'b00100, 16'd7, 16'd1, 2, -1, 1'b0, 8, 16, 7};
      tbl[3] = '{5'b00001, 16'd5, 16'd1, 0, 3, 1'b0, 2, -1, 0};
      tbl[4] = '{5'b00001, 16'd5, 16'd1, 0, -1, 1'b0, 6, 7, 0};
      tbl[5] = '{5'b00000, 16'd3, 16'd2, 0, -1, 1'b0, 0, 1, 0};
      tbl[6] = '{5'b00010, 16'd2, 16'd0, 0, -1, 1'b0, 3, 4, 0};
      tbl[7] = '{5'b11111, 16'd0, 16'd3, 0, -1, 1'b0, 3, 4, 0};
      tbl[8] = '{5'b01000, 16'd2, 16'd1, 0, 0, 1'b1, 0, -1, 0};
      tbl[9] = '{5'b01000, 16'd2, 16'd1, 2, -1, 1'b0, 3, 6, 2};

      // reset state
      rst_n = 1'b0;
      drive_idle();
      en_cfg = 5'h1f; end_cfg = 16'hffff; pass_cfg = 16'hffff;
      model_reset();
      #12;
      chk("reset_outputs", all_out, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // no activity until a start pulse
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_step();
         @(posedge clk); #1;
      end

      for (int i = 0; i < 10; i++) begin
         run_job(tbl[i].cfg, tbl[i].e, tbl[i].p, tbl[i].mode,
                 tbl[i].abort_k, tbl[i].abort_sel, beats, done_k);
         st = tbl[i].exp_stall;
`ifndef VEC_ADD_CTRL_STALL_CNT_EN
         st = 0;
`endif
         chk($sformatf("tbl%0d_beats", i), 64'(beats), 64'(tbl[i].exp_beats));
         chk($sformatf("tbl%0d_done_k", i), 64'(done_k), 64'(tbl[i].exp_done_k));
         chk($sformatf("tbl%0d_stall", i), 64'(stall_cnt), 64'(st));
      end

      // asynchronous reset in the middle of RUN
      drive_cycle(0, 0, 5'b00001, 16'd7, 16'd1, -1, 1'b0);
      @(negedge clk); check_step(); @(posedge clk); #1;
      for (int k = 1; k < 4; k++) begin
         drive_cycle(k, 0, 5'b00001, 16'd7, 16'd1, -1, 1'b0);
         @(negedge clk); check_step(); @(posedge clk); #1;
      end
      chk("midrun_pipe_active", 64'(pipe_en), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs", all_out, 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); check_step(); @(posedge clk); #1;
      end

      // randomized jobs against the model
      for (int j = 0; j < 30; j++) begin
         logic [4:0] rc;
         int ak;
         rc = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ak = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1;
         run_job(rc, 16'($urandom_range(0, 4)), 16'($urandom_range(0, 3)), 3,
                 ak, 1'($urandom_range(0, 1)), beats, done_k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
